iter_encryptor: RTL and testbench
=================================

# iter_encryptor

Parametrised iterative block encryptor: the next generation of the team's fixed-width `encryptor`. Width, round count and rotation are parameters; the block adds a start/ready/done handshake, one round per clock, and an optional CBC chaining mode with IV load. It sits between the host-side block buffer and the ciphertext sink, with one block in flight at a time.

## Interface
- `DATA_W`, 128: block and key width in bits (≥8).
- `ROUNDS`, 10: rounds per block (≥2).
- `ROT`, 1: left-rotate amount in the round function (1..DATA_W-1).
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  request to encrypt; sampled only while `ready`=1.
- `cbc`  input  1  1 = CBC mode, 0 = ECB; sampled with `start`.
- `iv_load`  input  1  CBC only: use `iv` instead of the chain register for this block.
- `iv`  input  DATA_W  initialisation vector.
- `plaintext`  input  DATA_W  block; sampled with `start`.
- `key`  input  DATA_W  key; sampled with `start`.
- `ready`  output  1  block idle, will accept `start`.
- `done`  output  1  one-cycle pulse: `ciphertext` updated.
- `ciphertext`  output  DATA_W  result; held until the next `done`.

## Operation
- Round function, all arithmetic mod 2^DATA_W: `k_r = key_q ^ r`, where `r` is the round index 0..ROUNDS-1, zero-extended. `s' = rotl(s ^ k_r, ROT) + k_r`.
- Output whitening: `ciphertext = s_final ^ key_q`.
- Block input: `s0 = plaintext ^ X`.
  - ECB: `X` = 0.
  - CBC with `iv_load`=1: `X` = `iv`.
  - CBC with `iv_load`=0: `X` = chain register.
- Chain register update: on every CBC completion, chain ← `ciphertext`. ECB blocks leave it unchanged.
- `iv_load` is ignored in ECB.
- FSM states:
  - IDLE: `ready`=1. On `start`: capture `key_q`, `cbc_q` and `s0`; set `r`=0; go to RUN.
  - RUN: `ready`=0. Each edge applies one round and increments `r`. On the edge that applies round ROUNDS-1: write `ciphertext`, set `done`=1, update chain if `cbc_q`, return to IDLE.
- `start` while RUN is ignored; there is no queueing.
- Input ports may change freely after the `start` edge.
- `ready` is decoded combinationally from the state. `done` is registered.

## Timing
- Reset (asynchronous, `rst`=0) clears everything immediately: state=IDLE, `ready`=1, `done`=0, `ciphertext`=0, chain=0, `r`=0. This holds even mid-RUN; the in-flight block is discarded with no `done`.
- Latency: `start` sampled at edge E0 → `done`=1 and new `ciphertext` in the cycle after edge E0+ROUNDS. `ready`=1 in that same cycle.
- `start` held high during the `done` cycle is accepted: back-to-back period is ROUNDS+1 cycles.
- `done` is high for exactly one cycle per block.
- `ciphertext` is stable between `done` pulses.
- Round counter width is `$clog2(ROUNDS)`; no wrap occurs because the FSM leaves RUN at ROUNDS-1.
- Reset release takes effect on the first rising edge with `rst`=1. `start` sampled on that edge is accepted.

## Structure
- Package `cipher_pkg`: the state enum (IDLE, RUN) and the rotate helper function.
- Sub-module `cipher_round`: purely combinational, takes `s`, `key_q`, `r` and produces `s'`, parameterised by DATA_W and ROT. It is instantiated once in the top and reused every cycle.
- Top `iter_encryptor` holds the FSM, the capture registers, the chain register and the output register.

## Test plan
All scenarios use DATA_W=16, ROUNDS=4, ROT=1.
- Reset: hold `rst`=0 and drive `start`=1 → `ready`=1, `done`=0, `ciphertext`=0x0000, no state change.
- ECB, key=0x0000, plaintext=0x0000 → `done` 4 cycles after the `start` edge, `ciphertext`=0x0011; `ready`=0 during the 4 RUN cycles.
- ECB, key=0x0100, plaintext=0x0000; change `key` and `plaintext` the cycle after `start` → `ciphertext`=0x1011, unaffected by the later input changes.
- CBC, key=0, iv=0: first block `iv_load`=1 with plaintext 0 → 0x0011. Second block, back-to-back (`start` held high), `iv_load`=0, plaintext 0 → 0x0121. The second `done` arrives exactly 5 cycles after the first.
- Drive `start` pulses during RUN → ignored: exactly one `done`, and the result matches the first request.
- Assert `rst`=0 two cycles into a block → outputs clear asynchronously; no `done` for the aborted block. A subsequent ECB key=0, plaintext=0 block gives 0x0011, and a following CBC block with `iv_load`=0 uses chain=0.

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared types and helpers for the iterative block encryptor.
package cipher_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Widest block the rotate helper supports; callers pass their real width.
  localparam int unsigned ROTL_MAX_W = 1024;

  function automatic logic [ROTL_MAX_W-1:0] rotl(input logic [ROTL_MAX_W-1:0] x,
                                                 input int unsigned w,
                                                 input int unsigned n);
    logic [ROTL_MAX_W-1:0] mask;
    mask = (w >= ROTL_MAX_W) ? '1 : ((ROTL_MAX_W'(1) << w) - ROTL_MAX_W'(1));
    return ((x << n) | (x >> (w - n))) & mask;
  endfunction

endpackage

// File: rtl/cipher_round.sv
// One combinational cipher round: s' = rotl(s ^ k_r, ROT) + k_r with k_r = key ^ r.
module cipher_round
  import cipher_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ROT    = 1,
  parameter int unsigned RW     = 4
) (
  input  logic [DATA_W-1:0] s_i,
  input  logic [DATA_W-1:0] key_i,
  input  logic [RW-1:0]     r_i,
  output logic [DATA_W-1:0] s_o
);

  logic [DATA_W-1:0] k_r;
  logic [DATA_W-1:0] mixed;

  assign k_r   = key_i ^ DATA_W'(r_i);
  assign mixed = s_i ^ k_r;
  assign s_o   = DATA_W'(rotl(ROTL_MAX_W'(mixed), DATA_W, ROT)) + k_r;

endmodule

// File: rtl/iter_encryptor.sv
// Iterative block encryptor: one round per clock, ECB or CBC with IV load.
module iter_encryptor
  import cipher_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ROUNDS = 10,
  parameter int unsigned ROT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cbc,
  input  logic              iv_load,
  input  logic [DATA_W-1:0] iv,
  input  logic [DATA_W-1:0] plaintext,
  input  logic [DATA_W-1:0] key,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] ciphertext
);

  localparam int unsigned   RW     = $clog2(ROUNDS);
  localparam logic [RW-1:0] LAST_R = RW'(ROUNDS - 1);

  state_e            state_q;
  logic [RW-1:0]     r_q;
  logic [DATA_W-1:0] s_q;
  logic [DATA_W-1:0] key_q;
  logic [DATA_W-1:0] chain_q;
  logic [DATA_W-1:0] ct_q;
  logic              cbc_q;
  logic              done_q;

  logic [DATA_W-1:0] x_d;
  logic [DATA_W-1:0] s_d;
  logic [DATA_W-1:0] ct_d;

  cipher_round #(
    .DATA_W(DATA_W),
    .ROT   (ROT),
    .RW    (RW)
  ) u_round (
    .s_i  (s_q),
    .key_i(key_q),
    .r_i  (r_q),
    .s_o  (s_d)
  );

  // Pre-whitening term for the incoming block; iv_load only matters in CBC.
  always_comb begin
    x_d = '0;
    if (cbc) x_d = iv_load ? iv : chain_q;
  end

  assign ct_d = s_d ^ key_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      s_q     <= '0;
      key_q   <= '0;
      chain_q <= '0;
      ct_q    <= '0;
      cbc_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            key_q   <= key;
            cbc_q   <= cbc;
            s_q     <= plaintext ^ x_d;
            r_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (r_q == LAST_R) begin
            ct_q    <= ct_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
            if (cbc_q) chain_q <= ct_d;
          end else begin
            s_q <= s_d;
            r_q <= r_q + RW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready      = (state_q == IDLE);
  assign done       = done_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_iter_encryptor.sv
// Scoreboard bench for iter_encryptor (DATA_W=16, ROUNDS=4, ROT=1).
module tb_iter_encryptor;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ROUNDS = 4;
  localparam int unsigned ROT    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cbc;
  logic        iv_load;
  logic [15:0] iv;
  logic [15:0] plaintext;
  logic [15:0] key;
  logic        ready;
  logic        done;
  logic [15:0] ciphertext;

  iter_encryptor #(
    .DATA_W(DATA_W),
    .ROUNDS(ROUNDS),
    .ROT   (ROT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cbc       (cbc),
    .iv_load   (iv_load),
    .iv        (iv),
    .plaintext (plaintext),
    .key       (key),
    .ready     (ready),
    .done      (done),
    .ciphertext(ciphertext)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [15:0] ct;
    int          start_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] hist_ct[$];
  int          hist_cyc[$];
  logic [15:0] exp_last;
  logic [15:0] m_chain;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: straight arithmetic on integers, mod 2^16.
  function automatic logic [15:0] ref_encrypt(input logic [15:0] k, input logic [15:0] s0);
    int unsigned s, kr, v;
    s = int'(s0);
    for (int r = 0; r < int'(ROUNDS); r++) begin
      kr = int'(k) ^ r;
      v  = (s ^ kr) & 32'hFFFF;
      v  = ((v << ROT) | (v >> (DATA_W - ROT))) & 32'hFFFF;
      s  = (v + kr) % 65536;
    end
    return 16'(s) ^ k;
  endfunction

  // Monitor: pops the scoreboard on every done, otherwise checks output hold.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      hist_ct.push_back(ciphertext);
      hist_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ciphertext", 32'(ciphertext), 32'(e.ct));
        check("latency", 32'(cyc - e.start_cyc), 32'(ROUNDS));
        check("ready_at_done", 32'(ready), 32'd1);
        exp_last = e.ct;
      end
    end else begin
      check("ct_hold", 32'(ciphertext), 32'(exp_last));
    end
  end

  task automatic issue(input logic [15:0] k, input logic [15:0] p, input logic c,
                       input logic il, input logic [15:0] v);
    int          guard;
    logic [15:0] x;
    logic [15:0] e;
    guard = 0;
    @(negedge clk);
    while (ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("ready_timeout", 32'd0, 32'd1);
    start     = 1'b1;
    key       = k;
    plaintext = p;
    cbc       = c;
    iv_load   = il;
    iv        = v;
    x = c ? (il ? v : m_chain) : 16'h0000;
    e = ref_encrypt(k, p ^ x);
    if (c) m_chain = e;
    @(posedge clk);
    #1;
    sb.push_back('{ct: e, start_cyc: cyc});
    start     = 1'b0;
    key       = 16'($urandom);
    plaintext = 16'($urandom);
    iv        = 16'($urandom);
    cbc       = 1'($urandom);
    iv_load   = 1'($urandom);
  endtask

  task automatic wait_dones(input int n);
    int guard;
    guard = 0;
    while (hist_ct.size() < n && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (hist_ct.size() < n) check("done_timeout", 32'(hist_ct.size()), 32'(n));
  endtask

  task automatic clear_hist();
    hist_ct.delete();
    hist_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    start     = 1'b1;
    cbc       = 1'b1;
    iv_load   = 1'b0;
    iv        = 16'hA5A5;
    plaintext = 16'h1234;
    key       = 16'hBEEF;
    exp_last  = 16'h0000;
    m_chain   = 16'h0000;

    // Reset held with start asserted: nothing moves.
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ct", 32'(ciphertext), 32'h0000);
    #2;
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 32'd1);

    // ECB key=0 plaintext=0, ready low for the four RUN cycles.
    clear_hist();
    issue(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("run_ready_low", 32'(ready), 32'd0);
    end
    wait_dones(1);
    check("kat_ecb_k0", 32'(hist_ct[0]), 32'h0011);

    // ECB key=0x0100; inputs scrambled right after start.
    clear_hist();
    issue(16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0000);
    wait_dones(1);
    check("kat_ecb_k100", 32'(hist_ct[0]), 32'h1011);

    // CBC back-to-back: IV load then chained block.
    clear_hist();
    issue(16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000);
    issue(16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF);
    wait_dones(2);
    check("kat_cbc_first", 32'(hist_ct[0]), 32'h0011);
    check("kat_cbc_second", 32'(hist_ct[1]), 32'h0121);
    check("b2b_period", 32'(hist_cyc[1] - hist_cyc[0]), 32'd5);

    // Start pulses during RUN are ignored.
    clear_hist();
    issue(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h0000);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_dones(1);
    repeat (8) @(negedge clk);
    #1;
    check("ignored_starts_count", 32'(hist_ct.size()), 32'd1);
    check("ignored_starts_ct", 32'(hist_ct[0]), 32'(ref_encrypt(16'h1234, 16'h5678)));

    // Asynchronous reset two cycles into a block.
    clear_hist();
    issue(16'h0F0F, 16'h3333, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    m_chain  = 16'h0000;
    exp_last = 16'h0000;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ct", 32'(ciphertext), 32'h0000);
    start = 1'b1;
    @(negedge clk);
    #2;
    start = 1'b0;
    rst   = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("abort_no_done", 32'(hist_ct.size()), 32'd0);
    issue(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    wait_dones(1);
    check("after_abort_ecb", 32'(hist_ct[0]), 32'h0011);
    issue(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000);
    wait_dones(2);
    check("after_abort_cbc_chain0", 32'(hist_ct[1]), 32'h0011);

    // Randomised mix of ECB / CBC / IV loads with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
    end

    begin
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (sb.size() != 0) check("drain", 32'(sb.size()), 32'd0);
    end
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
